game_input_sched: RTL and testbench

Input and gravity scheduler that sits between the debounced button front end and `game_control`. It turns held button levels into single-cycle command pulses on `key_*`, with DAS/ARR auto-repeat for left/right and repeat for soft drop. It generates the level-dependent gravity pulse `tick_game` and arbitrates all of these so that `game_control` sees at most one command per clock.

---
 rtl/game_input_sched.sv | 216 +++++++++++++++++++++
 tb/tb_game_input_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_input_sched.sv
// game_input_sched: converts debounced button levels into one-cycle command
// pulses (with DAS/ARR horizontal repeat and soft-drop repeat), generates the
// level-dependent gravity pulse, and arbitrates so at most one pulse leaves
// per clock. Priority: hold > drop > rotate_cw > rotate_ccw > left > right >
// down > gravity. Repeat frame counts are assumed to be at least 1.
module game_input_sched #(
  parameter int TICK_DIV    = 1_666_667,
  parameter int DAS_FRAMES  = 16,
  parameter int ARR_FRAMES  = 6,
  parameter int SOFT_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_rotate_cw,
  input  logic       btn_rotate_ccw,
  input  logic       btn_drop,
  input  logic       btn_hold,
  input  logic [3:0] level,
  input  logic       pause,
  input  logic       game_over,
  output logic       tick_game,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate_cw,
  output logic       key_rotate_ccw,
  output logic       key_drop,
  output logic       key_hold,
  output logic       key_drop_held,
  output logic       frame_tick
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int REP_MAX = (DAS_FRAMES > ARR_FRAMES)
                         ? ((DAS_FRAMES > SOFT_FRAMES) ? DAS_FRAMES : SOFT_FRAMES)
                         : ((ARR_FRAMES > SOFT_FRAMES) ? ARR_FRAMES : SOFT_FRAMES);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // Bit positions shared by the button vector and the pending/pulse vectors.
  // Lower index means higher arbitration priority.
  localparam int P_HOLD  = 0;
  localparam int P_DROP  = 1;
  localparam int P_RCW   = 2;
  localparam int P_RCCW  = 3;
  localparam int P_LEFT  = 4;
  localparam int P_RIGHT = 5;
  localparam int P_DOWN  = 6;
  localparam int P_GRAV  = 7;

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_e;
  typedef enum logic       {DIR_L, DIR_R}         dir_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       prev_q;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       pulse_q, pulse_d;
  h_state_e         h_state_q, h_state_d;
  dir_e             dir_q, dir_d;
  logic [REP_W-1:0] h_cnt_q, h_cnt_d;
  logic [REP_W-1:0] soft_q, soft_d;
  logic [5:0]       grav_q, grav_d;

  logic [6:0] btn_v;
  logic [6:0] rise;
  logic       freeze;
  logic       dir_held, opp_held;
  logic       left_set, right_set, down_set, grav_set;
  logic [5:0] grav_period, grav_inc;
  logic [7:0] set_v, pend_now, grant;

  assign btn_v  = {btn_down, btn_right, btn_left, btn_rotate_ccw,
                   btn_rotate_cw, btn_drop, btn_hold};
  assign rise   = btn_v & ~prev_q;
  assign freeze = pause | game_over;

  assign frame_tick = (div_q == DIV_W'(TICK_DIV - 1));
  assign div_d      = frame_tick ? '0 : div_q + DIV_W'(1);

  assign dir_held = (dir_q == DIR_R) ? btn_right : btn_left;
  assign opp_held = (dir_q == DIR_R) ? btn_left  : btn_right;

  // Horizontal DAS/ARR state machine: next state and repeat requests.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    h_state_d = h_state_q;
    dir_d     = dir_q;
    h_cnt_d   = h_cnt_q;
    left_set  = 1'b0;
    right_set = 1'b0;
    if (freeze) begin
      h_state_d = H_IDLE;
      h_cnt_d   = '0;
    end else if (h_state_q == H_IDLE) begin
      if (rise[P_LEFT] && !btn_right) begin
        left_set  = 1'b1;
        dir_d     = DIR_L;
        h_cnt_d   = REP_W'(DAS_FRAMES);
        h_state_d = H_DAS;
      end else if (rise[P_RIGHT] && !btn_left) begin
        right_set = 1'b1;
        dir_d     = DIR_R;
        h_cnt_d   = REP_W'(DAS_FRAMES);
        h_state_d = H_DAS;
      end
    end else if (!dir_held || opp_held) begin
      h_state_d = H_IDLE;
      h_cnt_d   = '0;
    end else if (frame_tick) begin
      if (h_cnt_q == REP_W'(1)) begin
        left_set  = (dir_q == DIR_L);
        right_set = (dir_q == DIR_R);
        h_cnt_d   = REP_W'(ARR_FRAMES);
        h_state_d = H_ARR;
      end else begin
        h_cnt_d = h_cnt_q - REP_W'(1);
      end
    end
  end

  // Soft-drop repeat: a zero count means inactive, so a key still held after a
  // freeze stays silent until it is pressed again.
  always_comb begin
    soft_d   = soft_q;
    down_set = 1'b0;
    if (freeze || !btn_down) begin
      soft_d = '0;
    end else if (rise[P_DOWN]) begin
      down_set = 1'b1;
      soft_d   = REP_W'(SOFT_FRAMES);
    end else if (frame_tick && soft_q != '0) begin
      if (soft_q == REP_W'(1)) begin
        down_set = 1'b1;
        soft_d   = REP_W'(SOFT_FRAMES);
      end else begin
        soft_d = soft_q - REP_W'(1);
      end
    end
  end

  // Gravity period lookup and frame counter; compared with >= so a level change
  // applies on the very next frame.
  always_comb begin
    if (level <= 4'd9)       grav_period = 6'd48 - (6'(level) * 6'd5);
    else if (level <= 4'd12) grav_period = 6'd2;
    else                     grav_period = 6'd1;
    grav_inc = grav_q + 6'd1;
    grav_d   = grav_q;
    grav_set = 1'b0;
    if (freeze || btn_down) begin
      grav_d = '0;
    end else if (frame_tick) begin
      if (grav_inc >= grav_period) begin
        grav_set = 1'b1;
        grav_d   = '0;
      end else begin
        grav_d = grav_inc;
      end
    end
  end

  // Arbiter: merge new requests into the pending set and grant the lowest set
  // bit (x & -x isolates it), so the issued pulse is one-hot or zero.
  always_comb begin
    set_v    = {grav_set, down_set, right_set, left_set, rise[3:0]};
    pend_now = pend_q | set_v;
    grant    = pend_now & (~pend_now + 8'd1);
    if (freeze) begin
      pend_d  = '0;
      pulse_d = '0;
    end else begin
      pend_d  = pend_now & ~grant;
      pulse_d = grant;
    end
  end

  // State registers; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      pulse_q   <= '0;
      h_state_q <= H_IDLE;
      dir_q     <= DIR_L;
      h_cnt_q   <= '0;
      soft_q    <= '0;
      grav_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      div_q     <= div_d;
      prev_q    <= btn_v;
      pend_q    <= pend_d;
      pulse_q   <= pulse_d;
      h_state_q <= h_state_d;
      dir_q     <= dir_d;
      h_cnt_q   <= h_cnt_d;
      soft_q    <= soft_d;
      grav_q    <= grav_d;
    end
  end

  assign key_hold       = pulse_q[P_HOLD];
  assign key_drop       = pulse_q[P_DROP];
  assign key_rotate_cw  = pulse_q[P_RCW];
  assign key_rotate_ccw = pulse_q[P_RCCW];
  assign key_left       = pulse_q[P_LEFT];
  assign key_right      = pulse_q[P_RIGHT];
  assign key_down       = pulse_q[P_DOWN];
  assign tick_game      = pulse_q[P_GRAV];
  // The previous-value register of btn_drop is exactly a one-cycle delay.
  assign key_drop_held  = prev_q[P_DROP];

endmodule

// File: tb/tb_game_input_sched.sv
// Testbench for game_input_sched: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_game_input_sched;

  localparam int TICK_DIV = 4;
  localparam int DAS      = 3;
  localparam int ARR      = 2;
  localparam int SOFT     = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] btn;  // 0 hold,1 drop,2 rcw,3 rccw,4 left,5 right,6 down
  logic [3:0] level;
  logic       pause, game_over;
  logic       tick_game, key_left, key_right, key_down;
  logic       key_rotate_cw, key_rotate_ccw, key_drop, key_hold;
  logic       key_drop_held, frame_tick;
  logic [7:0] obs;

  game_input_sched #(
    .TICK_DIV(TICK_DIV), .DAS_FRAMES(DAS), .ARR_FRAMES(ARR), .SOFT_FRAMES(SOFT)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn[4]), .btn_right(btn[5]), .btn_down(btn[6]),
    .btn_rotate_cw(btn[2]), .btn_rotate_ccw(btn[3]),
    .btn_drop(btn[1]), .btn_hold(btn[0]),
    .level(level), .pause(pause), .game_over(game_over),
    .tick_game(tick_game), .key_left(key_left), .key_right(key_right),
    .key_down(key_down), .key_rotate_cw(key_rotate_cw),
    .key_rotate_ccw(key_rotate_ccw), .key_drop(key_drop), .key_hold(key_hold),
    .key_drop_held(key_drop_held), .frame_tick(frame_tick)
  );

  assign obs = {tick_game, key_down, key_right, key_left,
                key_rotate_ccw, key_rotate_cw, key_drop, key_hold};

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state, expressed in frames-remaining / direction terms.
  int         m_div;
  logic [6:0] m_prev;
  logic [7:0] m_pend, m_out;
  int         m_hdir;   // -1 none, 0 left, 1 right
  int         m_hleft;  // frames until next horizontal repeat
  int         m_soft;   // frames until next soft-drop repeat, 0 = inactive
  int         m_grav;   // frames elapsed towards gravity
  logic       m_dh;

  typedef struct {
    logic [6:0] btn;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, actual, expected);
    end
  endtask

  function automatic int gperiod(input int lv);
    if (lv <= 9)  return 48 - 5 * lv;
    if (lv <= 12) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_div = 0; m_prev = '0; m_pend = '0; m_out = '0;
    m_hdir = -1; m_hleft = 0; m_soft = 0; m_grav = 0; m_dh = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic       ft, frz;
    logic [6:0] r;
    logic [7:0] newp, all;
    if (rst) begin
      model_reset();
      return;
    end
    ft   = (m_div == TICK_DIV - 1);
    frz  = pause | game_over;
    r    = btn & ~m_prev;
    newp = '0;
    newp[3:0] = r[3:0];
    if (frz) begin
      m_hdir = -1;
    end else if (m_hdir < 0) begin
      if (r[4] && !btn[5])      begin newp[4] = 1'b1; m_hdir = 0; m_hleft = DAS; end
      else if (r[5] && !btn[4]) begin newp[5] = 1'b1; m_hdir = 1; m_hleft = DAS; end
    end else if (!btn[4 + m_hdir] || btn[5 - m_hdir]) begin
      m_hdir = -1;
    end else if (ft) begin
      m_hleft--;
      if (m_hleft == 0) begin newp[4 + m_hdir] = 1'b1; m_hleft = ARR; end
    end
    if (frz || !btn[6]) m_soft = 0;
    else if (r[6]) begin newp[6] = 1'b1; m_soft = SOFT; end
    else if (ft && m_soft > 0) begin
      m_soft--;
      if (m_soft == 0) begin newp[6] = 1'b1; m_soft = SOFT; end
    end
    if (frz || btn[6]) m_grav = 0;
    else if (ft) begin
      m_grav++;
      if (m_grav >= gperiod(int'(level))) begin newp[7] = 1'b1; m_grav = 0; end
    end
    if (frz) begin
      m_pend = '0;
      m_out  = '0;
    end else begin
      all   = m_pend | newp;
      m_out = '0;
      for (int i = 0; i < 8; i++) begin
        if (all[i]) begin m_out[i] = 1'b1; all[i] = 1'b0; break; end
      end
      m_pend = all;
    end
    m_prev = btn;
    m_dh   = btn[1];
    m_div  = ft ? 0 : m_div + 1;
  endtask

  // One clock: model, edge, then compare everything against the model.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("model_pulses", obs, m_out);
    check("model_frame_tick", frame_tick, (m_div == TICK_DIV - 1));
    check("model_drop_held", key_drop_held, m_dh);
    check("one_hot", ($countones(obs) <= 1), 1);
  endtask

  initial begin
    int last, gap, cnt, nk, nt;
    logic found;
    rst = 1'b1; btn = '0; level = 4'd0; pause = 1'b0; game_over = 1'b0;
    model_reset();

    vt[0] = '{7'b0010101, 8'h01};
    vt[1] = '{7'b0010101, 8'h04};
    vt[2] = '{7'b0010101, 8'h10};
    vt[3] = '{7'b0010101, 8'h00};
    vt[4] = '{7'b0000000, 8'h00};
    vt[5] = '{7'b0000010, 8'h02};
    vt[6] = '{7'b0000000, 8'h00};

    // Reset held for 5 cycles: all outputs low.
    repeat (5) begin
      step();
      check("reset_outputs", {frame_tick, key_drop_held, obs}, 0);
    end
    rst = 1'b0;

    // Idle at level 0: gravity every 48 frames, no key pulses.
    last = -1; gap = 0; nk = 0;
    repeat (400) begin
      step();
      if (tick_game) begin
        if (last >= 0) gap = cyc - last;
        last = cyc;
      end
      if (obs[6:0] != 0) nk++;
    end
    check("grav_period_l0", gap, 192);
    check("idle_no_keys", nk, 0);

    // Simultaneous hold/rotate_cw/left edges, then a drop edge.
    for (int i = 0; i < 7; i++) begin
      btn = vt[i].btn;
      step();
      check($sformatf("vec%0d", i), obs, vt[i].exp);
    end

    // Left held 40 cycles: pulse at edge+1, then repeats every 2 frames.
    btn = 7'b0010000;
    step();
    check("left_first", obs, 8'h10);
    last = cyc; gap = 0; cnt = 0;
    repeat (39) begin
      step();
      if (key_left) begin gap = cyc - last; last = cyc; cnt++; end
    end
    check("left_arr_gap", gap, 8);
    check("left_repeats_min", (cnt >= 3), 1);
    btn = '0;
    nk = 0;
    repeat (20) begin step(); if (obs[6:0] != 0) nk++; end
    check("left_release_silent", nk, 0);

    // Reset mid-operation: pending items are dropped.
    btn = 7'b0000111;
    step();
    check("mid_hold_first", obs, 8'h01);
    rst = 1'b1;
    #1;
    check("reset_async", {key_drop_held, obs}, 0);
    btn = '0;
    step();
    rst = 1'b0;
    nk = 0;
    repeat (6) begin step(); if (obs != 0) nk++; end
    check("reset_pending_lost", nk, 0);

    // Level 15: rotate_ccw edge in the cycle gravity pends.
    level = 4'd15;
    repeat (8) step();
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (frame_tick) found = 1'b1;
      else step();
    end
    check("t4_align", found, 1);
    btn[3] = 1'b1;
    step();
    check("t4_ccw_first", obs, 8'h08);
    step();
    check("t4_grav_next", obs, 8'h80);
    btn = '0;
    repeat (4) step();

    // Soft drop held at level 15: no gravity, down every 8 cycles.
    btn[6] = 1'b1;
    step();
    check("t5_down_edge", obs, 8'h40);
    last = cyc; gap = 0; cnt = 0; nt = 0;
    repeat (32) begin
      step();
      if (tick_game) nt++;
      if (key_down) begin gap = cyc - last; last = cyc; cnt++; end
    end
    check("t5_no_gravity", nt, 0);
    check("t5_down_gap", gap, 8);
    check("t5_down_count_min", (cnt >= 3), 1);
    btn[6] = 1'b0;
    last = -1; gap = 0; nt = 0;
    repeat (24) begin
      step();
      if (tick_game) begin
        if (last >= 0) gap = cyc - last;
        last = cyc; nt++;
      end
    end
    check("t5_grav_resume_gap", gap, 4);
    check("t5_grav_resume_min", (nt >= 5), 1);

    // Right held into ARR, pause, release with right still held.
    level = 4'd0;
    btn[5] = 1'b1;
    repeat (30) step();
    pause = 1'b1;
    nk = 0;
    repeat (20) begin step(); if (obs[6:0] != 0) nk++; end
    check("t6_pause_silent", nk, 0);
    pause = 1'b0;
    nk = 0;
    repeat (20) begin step(); if (obs[6:0] != 0) nk++; end
    check("t6_held_after_pause_silent", nk, 0);
    btn[5] = 1'b0;
    step();
    btn[5] = 1'b1;
    step();
    check("t6_new_edge", obs, 8'h20);
    btn = '0;

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 59) == 0)  pause = ~pause;
      if ($urandom_range(0, 299) == 0) game_over = ~game_over;
      if ($urandom_range(0, 99) == 0)  level = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
